// File: rtl/hpf_cfg_pkg.sv
// Shared constants and state encoding for the HPF coefficient loader.
// Defaults here are also used by the filter top.
package hpf_cfg_pkg;

   localparam int HPF_NUM_COEFS  = 5;
   localparam int HPF_COEF_WIDTH = 32;
   localparam int HPF_SEL_WIDTH  = 3;

   localparam logic [31:0] HPF_DEF_C0 = 32'h0000FF00;
   localparam logic [31:0] HPF_DEF_C1 = 32'hFFFF0100;
   localparam logic [31:0] HPF_DEF_C2 = 32'h0000FE07;

   typedef enum logic [1:0] {
      ST_FLUSH,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN
   } load_state_t;

endpackage

// File: rtl/hpf_coef_shadow_regs.sv
// Shadow coefficient bank: one write port, one combinational read port.
// Ports: clk, reset, wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module hpf_coef_shadow_regs
   import hpf_cfg_pkg::*;
#(
   parameter int NUM_COEFS  = HPF_NUM_COEFS,
   parameter int COEF_WIDTH = HPF_COEF_WIDTH,
   parameter int SEL_WIDTH  = HPF_SEL_WIDTH,
   parameter logic [COEF_WIDTH-1:0] DEF_C0 = COEF_WIDTH'(HPF_DEF_C0),
   parameter logic [COEF_WIDTH-1:0] DEF_C1 = COEF_WIDTH'(HPF_DEF_C1),
   parameter logic [COEF_WIDTH-1:0] DEF_C2 = COEF_WIDTH'(HPF_DEF_C2)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [SEL_WIDTH-1:0]  wr_addr,
   input  logic [COEF_WIDTH-1:0] wr_data,
   input  logic [SEL_WIDTH-1:0]  rd_addr,
   output logic [COEF_WIDTH-1:0] rd_data
);

   logic [COEF_WIDTH-1:0] regs [NUM_COEFS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_COEFS; i++) begin
            regs[i] <= (i == 0) ? DEF_C0 :
                       (i == 1) ? DEF_C1 : DEF_C2;
         end
      end else if (wr_en && (32'(wr_addr) < NUM_COEFS)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if (32'(rd_addr) < NUM_COEFS) begin
         rd_data = regs[rd_addr];
      end
   end

endmodule

// File: rtl/hpf_coefficient_loader.sv
// Pushes the shadow coefficient bank to the IIR integrator bank,
// framing each load with filter reset (FLUSH) and a run gate (RUN).
// Host side: cfg_valid/cfg_ready/cfg_addr/cfg_data writes, cfg_commit,
// cfg_err. Filter side: coefficient, reg_select, enable_reg_select,
// filter_reset, filter_run. Status: busy, done.
module hpf_coefficient_loader
   import hpf_cfg_pkg::*;
#(
   parameter int NUM_COEFS  = HPF_NUM_COEFS,
   parameter int COEF_WIDTH = HPF_COEF_WIDTH,
   parameter int SEL_WIDTH  = HPF_SEL_WIDTH,
   parameter logic [COEF_WIDTH-1:0] DEF_C0 = COEF_WIDTH'(HPF_DEF_C0),
   parameter logic [COEF_WIDTH-1:0] DEF_C1 = COEF_WIDTH'(HPF_DEF_C1),
   parameter logic [COEF_WIDTH-1:0] DEF_C2 = COEF_WIDTH'(HPF_DEF_C2)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [SEL_WIDTH-1:0]  cfg_addr,
   input  logic [COEF_WIDTH-1:0] cfg_data,
   input  logic                  cfg_commit,
   output logic                  cfg_err,
   output logic [COEF_WIDTH-1:0] coefficient,
   output logic [SEL_WIDTH-1:0]  reg_select,
   output logic                  enable_reg_select,
   output logic                  filter_reset,
   output logic                  filter_run,
   output logic                  busy,
   output logic                  done
);

   if ((NUM_COEFS < 1) || (NUM_COEFS > 2**SEL_WIDTH)) begin : g_chk
      $error("NUM_COEFS must be in 1..2**SEL_WIDTH");
   end

   localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(NUM_COEFS - 1);

   load_state_t           state_q, state_d;
   logic [SEL_WIDTH-1:0]  idx_q, idx_d;
   logic                  pend_q, pend_d;
   logic                  addr_ok, wr_fire;
   logic                  ers_d;
   logic [SEL_WIDTH-1:0]  sel_d;
   logic [COEF_WIDTH-1:0] coef_d, rd_data;

   assign addr_ok      = 32'(cfg_addr) < NUM_COEFS;
   assign cfg_ready    = !reset &&
                         ((state_q == ST_RUN) || (state_q == ST_SETTLE));
   assign wr_fire      = cfg_valid && cfg_ready;
   assign filter_reset = state_q == ST_FLUSH;
   assign filter_run   = state_q == ST_RUN;
   assign busy         = state_q != ST_RUN;

   hpf_coef_shadow_regs #(
      .NUM_COEFS  (NUM_COEFS),
      .COEF_WIDTH (COEF_WIDTH),
      .SEL_WIDTH  (SEL_WIDTH),
      .DEF_C0     (DEF_C0),
      .DEF_C1     (DEF_C1),
      .DEF_C2     (DEF_C2)
   ) u_shadow (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_fire && addr_ok),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_addr (idx_d),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      unique case (state_q)
         ST_FLUSH: begin
            state_d = ST_LOAD;
            idx_d   = '0;
         end
         ST_LOAD: begin
            if (idx_q == LAST) state_d = ST_SETTLE;
            else               idx_d   = idx_q + 1'b1;
         end
         ST_SETTLE: state_d = ST_RUN;
         ST_RUN: begin
            if (cfg_commit || pend_q) state_d = ST_FLUSH;
         end
         default: state_d = ST_FLUSH;
      endcase
      // Commits while a load is in flight collapse into one replay;
      // the flag drops as the replay's FLUSH is entered.
      if (state_q != ST_RUN) pend_d = pend_q || cfg_commit;
      else                   pend_d = 1'b0;
      // Bus outputs are registered from next-state values so they
      // line up with the cycle the state register shows.
      ers_d  = state_d == ST_LOAD;
      sel_d  = ers_d ? idx_d : '0;
      coef_d = ers_d ? rd_data : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= ST_FLUSH;
         idx_q             <= '0;
         pend_q            <= 1'b0;
         enable_reg_select <= 1'b0;
         reg_select        <= '0;
         coefficient       <= '0;
         done              <= 1'b0;
         cfg_err           <= 1'b0;
      end else begin
         state_q           <= state_d;
         idx_q             <= idx_d;
         pend_q            <= pend_d;
         enable_reg_select <= ers_d;
         reg_select        <= sel_d;
         coefficient       <= coef_d;
         done              <= state_q == ST_SETTLE;
         cfg_err           <= wr_fire && !addr_ok;
      end
   end

endmodule

// File: tb/tb_hpf_coefficient_loader.sv
// Self-checking bench for hpf_coefficient_loader: scoreboard of
// expected bus words plus cycle-exact sequencing checks.
module tb_hpf_coefficient_loader;

   localparam logic [31:0] D0 = 32'h0000FF00;
   localparam logic [31:0] D1 = 32'hFFFF0100;
   localparam logic [31:0] D2 = 32'h0000FE07;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_commit;
   logic        cfg_err;
   logic [31:0] coefficient;
   logic [2:0]  reg_select;
   logic        enable_reg_select;
   logic        filter_reset;
   logic        filter_run;
   logic        busy;
   logic        done;

   int          n_vec = 0;
   int          n_err = 0;
   int          n;
   logic [34:0] exp_q [$];
   logic [31:0] shadow_m [5];

   always #5 clk = ~clk;

   hpf_coefficient_loader dut (
      .clk               (clk),
      .reset             (reset),
      .cfg_valid         (cfg_valid),
      .cfg_ready         (cfg_ready),
      .cfg_addr          (cfg_addr),
      .cfg_data          (cfg_data),
      .cfg_commit        (cfg_commit),
      .cfg_err           (cfg_err),
      .coefficient       (coefficient),
      .reg_select        (reg_select),
      .enable_reg_select (enable_reg_select),
      .filter_reset      (filter_reset),
      .filter_run        (filter_run),
      .busy              (busy),
      .done              (done)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic reset_model();
      shadow_m[0] = D0;
      shadow_m[1] = D1;
      for (int i = 2; i < 5; i++) shadow_m[i] = D2;
   endtask

   task automatic push_load();
      for (int i = 0; i < 5; i++)
         exp_q.push_back({3'(i), shadow_m[i]});
   endtask

   task automatic cyc();
      logic [34:0] e;
      @(negedge clk);
      if (enable_reg_select) begin
         if (exp_q.size() == 0) begin
            chk("bus_extra", {reg_select, coefficient}, 0);
         end else begin
            e = exp_q.pop_front();
            chk("bus", {reg_select, coefficient}, e);
         end
      end else begin
         chk("bus_idle", {reg_select, coefficient}, 0);
      end
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         cyc();
         cnt++;
      end while (!done && cnt < 40);
      if (!done) chk("done_timeout", done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      cfg_valid  = 1'b0;
      cfg_addr   = '0;
      cfg_data   = '0;
      cfg_commit = 1'b0;
      reset_model();

      // reset state
      repeat (3) cyc();
      chk("rst_freset", filter_reset, 1);
      chk("rst_busy", busy, 1);
      chk("rst_ers", enable_reg_select, 0);
      chk("rst_run", filter_run, 0);
      chk("rst_done", done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_ready", cfg_ready, 0);

      // auto-load after reset
      reset = 1'b0;
      push_load();
      chk("post_rst_flush", filter_reset, 1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("auto_ld_en", enable_reg_select, 1);
         chk("auto_ld_freset", filter_reset, 0);
      end
      cyc();
      chk("settle_en", enable_reg_select, 0);
      chk("settle_ready", cfg_ready, 1);
      chk("settle_run", filter_run, 0);
      cyc();
      chk("auto_done", done, 1);
      chk("auto_run", filter_run, 1);
      chk("auto_busy", busy, 0);
      chk("auto_q", exp_q.size(), 0);

      // write slot 2, then commit
      cfg_valid = 1'b1;
      cfg_addr  = 3'd2;
      cfg_data  = 32'h00010000;
      cyc();
      chk("wr_done_clr", done, 0);
      cfg_valid   = 1'b0;
      shadow_m[2] = 32'h00010000;
      cfg_commit  = 1'b1;
      push_load();
      cyc();
      cfg_commit = 1'b0;
      chk("c_flush", filter_reset, 1);
      chk("c_run_off", filter_run, 0);
      wait_done(n);
      chk("commit_lat", n, 7);
      chk("commit_q", exp_q.size(), 0);

      // commits inside LOAD collapse into one replay
      cfg_commit = 1'b1;
      push_load();
      cyc();
      cfg_commit = 1'b0;
      cyc();
      cyc();
      chk("l2_sel", reg_select, 1);
      push_load();
      cfg_commit = 1'b1;
      repeat (3) cyc();
      cfg_commit = 1'b0;
      wait_done(n);
      chk("pend_first_lat", n, 2);
      chk("pend_first_run", filter_run, 1);
      cyc();
      chk("pend_reflush", filter_reset, 1);
      chk("pend_done_clr", done, 0);
      wait_done(n);
      chk("pend_lat", n, 7);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("idle_run", filter_run, 1);
         chk("idle_freset", filter_reset, 0);
         chk("idle_done", done, 0);
      end
      chk("pend_q", exp_q.size(), 0);

      // write held off during FLUSH/LOAD lands in SETTLE
      cfg_commit = 1'b1;
      push_load();
      cyc();
      cfg_commit = 1'b0;
      cfg_valid  = 1'b1;
      cfg_addr   = 3'd1;
      cfg_data   = 32'hA5A50001;
      chk("hold_rdy_flush", cfg_ready, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("hold_rdy_load", cfg_ready, 0);
      end
      cyc();
      chk("hold_rdy_settle", cfg_ready, 1);
      cyc();
      chk("hold_done", done, 1);
      chk("hold_err", cfg_err, 0);
      chk("hold_q", exp_q.size(), 0);
      shadow_m[1] = 32'hA5A50001;

      // out-of-range write
      cfg_addr = 3'd6;
      cfg_data = 32'hDEADBEEF;
      chk("oor_ready", cfg_ready, 1);
      cyc();
      cfg_valid = 1'b0;
      chk("oor_err", cfg_err, 1);
      cyc();
      chk("oor_err_clr", cfg_err, 0);

      // write and commit in the same RUN cycle
      cfg_valid   = 1'b1;
      cfg_addr    = 3'd0;
      cfg_data    = 32'h80001234;
      cfg_commit  = 1'b1;
      shadow_m[0] = 32'h80001234;
      push_load();
      cyc();
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
      chk("wc_flush", filter_reset, 1);
      wait_done(n);
      chk("wc_lat", n, 7);
      chk("wc_q", exp_q.size(), 0);

      // reset during the third LOAD cycle
      cfg_commit = 1'b1;
      push_load();
      cyc();
      cfg_commit = 1'b0;
      repeat (3) cyc();
      chk("l3_sel", reg_select, 2);
      chk("l3_en", enable_reg_select, 1);
      reset = 1'b1;
      exp_q.delete();
      reset_model();
      cyc();
      chk("mid_rst_ers", enable_reg_select, 0);
      chk("mid_rst_freset", filter_reset, 1);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_run", filter_run, 0);
      chk("mid_rst_ready", cfg_ready, 0);
      chk("mid_rst_done", done, 0);
      reset = 1'b0;
      push_load();
      wait_done(n);
      chk("rst_reload_lat", n, 7);
      chk("rst_reload_q", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
